bus_arbiter_rr4: RTL and testbench
==================================

// Module: bus_arbiter_rr4
// PURPOSE
//  Round-robin arbiter sharing one resource (bus/DMA channel) between four requesters.
//  - Requests pass through per-input bubble inversion, then a 4-input NOR forms the
//    "no request pending" idle term.
//  - Grants are one-hot and registered, with a mandatory one-cycle dead turnaround
//    between owners.
//  - An optional hold-timeout preempts an owner that hogs the resource while others wait.
// PARAMETERS
//  BubblesMask  4'b0000  bit i=1: req[i] is active-low (inverted before use)
//  MAX_HOLD     16       grant cycles before preemption if others pending; 0 = no timeout
//  CNT_W        8        hold counter width; MAX_HOLD must be < 2**CNT_W
// PORTS
//  sysclk     in   1  system clock, all state on rising edge
//  reset      in   1  asynchronous, active-high reset
//  req        in   4  raw request lines, polarity per BubblesMask
//  gnt        out  4  one-hot grant, registered; all-zero = no owner
//  gnt_valid  out  1  registered, =|gnt
//  gnt_id     out  2  index of current/last owner, registered
//  idle       out  1  combinational ~(r0|r1|r2|r3) of effective requests
//  timeout    out  1  registered one-cycle pulse when an owner is preempted
// BEHAVIOUR
//  - Effective request: r[i] = BubblesMask[i] ? ~req[i] : req[i].
//  - Reset (async, immediate): state=IDLE, gnt=0, gnt_valid=0, gnt_id=0, timeout=0,
//    hold_cnt=0, last=3 (so requester 0 wins first).
//  - States:
//    - IDLE: gnt=0. If any r: pick first set bit searching last+1, last+2, ... (mod 4);
//      next state GRANT; load gnt/gnt_id; last<=winner; hold_cnt<=0.
//    - GRANT: gnt held constant.
//      - r[owner]=0 -> TURN.
//      - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 and any other r set -> TURN,
//        timeout=1 for that one cycle.
//      - Else stay; hold_cnt increments, saturating at MAX_HOLD-1 (no wrap).
//    - TURN: gnt=0 for exactly one cycle. If any r: arbitrate as in IDLE and go to GRANT,
//      else go to IDLE.
//  - Latency: r sampled high at edge N in IDLE -> gnt visible after edge N (one cycle).
//    Owner release to next grant: 2 cycles (TURN + grant).
//  - A preempted owner still requesting competes normally; round-robin places it last.
//  - Single requester, continuous request, timeout reached with no others pending:
//    keep grant, no timeout pulse.
//  - Request changes during TURN are honoured at the TURN->GRANT decision edge.
//  - gnt_id retains the last owner while gnt=0.
//  - gnt is never multi-hot; it is never non-zero in IDLE or TURN.
//  - idle depends only on req and BubblesMask, independent of state; valid during reset.
// TESTING
//  1. Assert reset mid-GRANT (gnt=0010) -> gnt=0000, gnt_id=0, timeout=0 before next edge.
//  2. Mask=0000; req=0001 after reset -> gnt=0001, gnt_id=0 one cycle later.
//     Drop req -> gnt=0000 next cycle (TURN), then IDLE.
//  3. req=1111 held, each owner drops its bit after 3 grant cycles -> grant order
//     0001,0010,0100,1000,0001; one zero cycle between each.
//  4. MAX_HOLD=4; req=0011 held -> gnt=0001 for 4 cycles, timeout=1 with the dead cycle,
//     then gnt=0010.
//  5. MAX_HOLD=4; req=0100 only, held 20 cycles -> gnt=0100 throughout, timeout never 1.
//  6. Mask=1111: req=1111 -> idle=1, no grant. req=1110 -> idle=0, gnt=0001.

Source files
------------

// File: rtl/bus_arbiter_rr4.sv
// Four-way round-robin bus arbiter with registered one-hot grant, a one-cycle dead
// turnaround between owners, and an optional hold-timeout that preempts a hogging owner.
module bus_arbiter_rr4 #(
    parameter logic [3:0]  BubblesMask = 4'b0000,
    parameter int unsigned MAX_HOLD    = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic [1:0] gnt_id,
    output logic       idle,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    localparam bit TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = TIMEOUT_EN ? CNT_W'(MAX_HOLD - 1) : {CNT_W{1'b0}};

    // Search last+1, last+2, ... (mod 4); bit 2 of the result flags that a winner exists.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic       found;
        logic [1:0] win;
        logic [1:0] cand;
        found = 1'b0;
        win   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!found && r[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        return {found, win};
    endfunction

    state_t           state_r, state_n;
    logic [CNT_W-1:0] hold_cnt_r, hold_cnt_n;
    logic [1:0]       last_r, last_n;
    logic [3:0]       gnt_n;
    logic [1:0]       gnt_id_n;
    logic             timeout_n;

    logic [3:0] eff_req_s;
    logic [2:0] pick_s;
    logic       pick_found_s;
    logic [1:0] pick_idx_s;
    logic       owner_req_s;
    logic       others_s;
    logic       preempt_s;

    assign eff_req_s    = req ^ BubblesMask;
    assign idle         = ~(eff_req_s[0] | eff_req_s[1] | eff_req_s[2] | eff_req_s[3]);
    assign pick_s       = rr_pick(eff_req_s, last_r);
    assign pick_found_s = pick_s[2];
    assign pick_idx_s   = pick_s[1:0];
    // While in GRANT, gnt_id names the owner and gnt masks it out of the contenders.
    assign owner_req_s  = eff_req_s[gnt_id];
    assign others_s     = |(eff_req_s & ~gnt);
    assign preempt_s    = TIMEOUT_EN && (hold_cnt_r == HOLD_LAST) && others_s;

    // State, counters and all registered outputs.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= {CNT_W{1'b0}};
            last_r     <= 2'd3;
            gnt        <= 4'b0000;
            gnt_valid  <= 1'b0;
            gnt_id     <= 2'd0;
            timeout    <= 1'b0;
        end else begin
            state_r    <= state_n;
            hold_cnt_r <= hold_cnt_n;
            last_r     <= last_n;
            gnt        <= gnt_n;
            gnt_valid  <= |gnt_n;
            gnt_id     <= gnt_id_n;
            timeout    <= timeout_n;
        end
    end

    // Next-state, hold counter and round-robin pointer.
    always_comb begin
        state_n    = state_r;
        hold_cnt_n = hold_cnt_r;
        last_n     = last_r;
        case (state_r)
            ST_IDLE, ST_TURN: begin
                if (pick_found_s) begin
                    state_n    = ST_GRANT;
                    hold_cnt_n = {CNT_W{1'b0}};
                    last_n     = pick_idx_s;
                end else begin
                    state_n    = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!owner_req_s || preempt_s) begin
                    state_n = ST_TURN;
                end else if (TIMEOUT_EN && (hold_cnt_r != HOLD_LAST)) begin
                    hold_cnt_n = hold_cnt_r + CNT_W'(1);
                end else begin
                    hold_cnt_n = hold_cnt_r;
                end
            end
            default: begin
                state_n    = ST_IDLE;
                hold_cnt_n = {CNT_W{1'b0}};
            end
        endcase
    end

    // Next values of the registered grant outputs.
    always_comb begin
        gnt_n     = 4'b0000;
        gnt_id_n  = gnt_id;
        timeout_n = 1'b0;
        case (state_r)
            ST_IDLE, ST_TURN: begin
                if (pick_found_s) begin
                    gnt_n    = 4'b0001 << pick_idx_s;
                    gnt_id_n = pick_idx_s;
                end else begin
                    gnt_n    = 4'b0000;
                end
            end
            ST_GRANT: begin
                if (!owner_req_s) begin
                    gnt_n = 4'b0000;
                end else if (preempt_s) begin
                    gnt_n     = 4'b0000;
                    timeout_n = 1'b1;
                end else begin
                    gnt_n = gnt;
                end
            end
            default: begin
                gnt_n = 4'b0000;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter_rr4.sv
// Bench for bus_arbiter_rr4: three instances (default, short timeout, inverted inputs)
// share one req bus and are compared every cycle against an owner/pointer model.
module tb_bus_arbiter_rr4;

    localparam logic [3:0] MASK [3] = '{4'b0000, 4'b0000, 4'b1111};
    localparam int         MH   [3] = '{16, 4, 4};

    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic [3:0] req    = 4'b0000;

    logic [3:0] gnt_w   [3];
    logic       valid_w [3];
    logic [1:0] id_w    [3];
    logic       idle_w  [3];
    logic       to_w    [3];

    bus_arbiter_rr4 #(.BubblesMask(4'b0000), .MAX_HOLD(16), .CNT_W(8)) dut_a (
        .sysclk(sysclk), .reset(reset), .req(req), .gnt(gnt_w[0]), .gnt_valid(valid_w[0]),
        .gnt_id(id_w[0]), .idle(idle_w[0]), .timeout(to_w[0]));
    bus_arbiter_rr4 #(.BubblesMask(4'b0000), .MAX_HOLD(4), .CNT_W(8)) dut_b (
        .sysclk(sysclk), .reset(reset), .req(req), .gnt(gnt_w[1]), .gnt_valid(valid_w[1]),
        .gnt_id(id_w[1]), .idle(idle_w[1]), .timeout(to_w[1]));
    bus_arbiter_rr4 #(.BubblesMask(4'b1111), .MAX_HOLD(4), .CNT_W(8)) dut_c (
        .sysclk(sysclk), .reset(reset), .req(req), .gnt(gnt_w[2]), .gnt_valid(valid_w[2]),
        .gnt_id(id_w[2]), .idle(idle_w[2]), .timeout(to_w[2]));

    always #5 sysclk = ~sysclk;

    int errors = 0;
    int checks = 0;

    // Reference: who owns the bus (-1 = nobody), the rotation pointer, grant age.
    int   m_owner [3];
    int   m_last  [3];
    int   m_hold  [3];
    int   m_id    [3];
    logic m_to    [3];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_owner[k] = -1;
            m_last[k]  = 3;
            m_hold[k]  = 0;
            m_id[k]    = 0;
            m_to[k]    = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [3:0] r;
        int w;
        for (int k = 0; k < 3; k++) begin
            r = req ^ MASK[k];
            m_to[k] = 1'b0;
            if (m_owner[k] >= 0) begin
                if (!r[m_owner[k]]) begin
                    m_owner[k] = -1;
                end else if (MH[k] != 0 && m_hold[k] == MH[k] - 1 &&
                             (r & ~(4'b0001 << m_owner[k])) != 4'b0000) begin
                    m_owner[k] = -1;
                    m_to[k]    = 1'b1;
                end else if (MH[k] != 0 && m_hold[k] < MH[k] - 1) begin
                    m_hold[k]++;
                end
            end else if (r != 4'b0000) begin
                for (int i = 1; i <= 4; i++) begin
                    w = (m_last[k] + i) % 4;
                    if (m_owner[k] < 0 && r[w]) m_owner[k] = w;
                end
                m_last[k] = m_owner[k];
                m_id[k]   = m_owner[k];
                m_hold[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] eg;
        for (int k = 0; k < 3; k++) begin
            eg = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
            check($sformatf("gnt%0d", k), {4'b0, gnt_w[k]}, {4'b0, eg});
            check($sformatf("valid%0d", k), {7'b0, valid_w[k]}, {7'b0, (eg != 4'b0000)});
            check($sformatf("id%0d", k), {6'b0, id_w[k]}, 8'(m_id[k]));
            check($sformatf("timeout%0d", k), {7'b0, to_w[k]}, {7'b0, m_to[k]});
            check($sformatf("idle%0d", k), {7'b0, idle_w[k]}, {7'b0, ((req ^ MASK[k]) == 4'b0000)});
        end
    endtask

    task automatic cycle();
        @(posedge sysclk);
        model_step();
        #1;
        check_all();
    endtask

    // Reset lands mid-cycle; outputs must clear before the next clock edge.
    task automatic do_reset();
        @(negedge sysclk);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        check("rst_gnt", {4'b0, gnt_w[0]}, 8'h00);
        check("rst_id", {6'b0, id_w[0]}, 8'h00);
        check("rst_to", {7'b0, to_w[0]}, 8'h00);
        @(negedge sysclk);
        reset = 1'b0;
    endtask

    logic [3:0] t3_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] t4_gnt   [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
    logic       t4_to    [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int gc;
        int n;
        model_reset();
        reset = 1'b1;
        #12;
        reset = 1'b0;

        // Single requester grant and release through TURN back to IDLE.
        do_reset();
        req = 4'b0001;
        cycle();
        check("t2_gnt", {4'b0, gnt_w[0]}, 8'h01);
        check("t2_id", {6'b0, id_w[0]}, 8'h00);
        req = 4'b0000;
        cycle();
        check("t2_turn", {4'b0, gnt_w[0]}, 8'h00);
        cycle();
        check("t2_idle", {4'b0, gnt_w[0]}, 8'h00);

        // Reset asserted while requester 1 owns the bus.
        req = 4'b0010;
        cycle();
        check("t1_pre", {4'b0, gnt_w[0]}, 8'h02);
        do_reset();

        // Rotation through all four with a dead cycle between owners.
        req = 4'b1111;
        gc = 0;
        n  = 0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            cycle();
            if (m_owner[0] >= 0) begin
                if (gc == 0) begin
                    check("t3_order", {4'b0, gnt_w[0]}, {4'b0, t3_order[n]});
                    n++;
                end
                gc++;
                if (gc == 3) req = 4'b1111 & ~(4'b0001 << m_owner[0]);
            end else begin
                check("t3_dead", {4'b0, gnt_w[0]}, 8'h00);
                gc  = 0;
                req = 4'b1111;
            end
        end
        check("t3_count", 8'(n), 8'd5);

        // Hold timeout preempts owner 0 in favour of owner 1.
        do_reset();
        req = 4'b0011;
        for (int c = 0; c < 6; c++) begin
            cycle();
            check("t4_gnt", {4'b0, gnt_w[1]}, {4'b0, t4_gnt[c]});
            check("t4_to", {7'b0, to_w[1]}, {7'b0, t4_to[c]});
        end

        // Lone requester past the timeout keeps the bus.
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            cycle();
            check("t5_gnt", {4'b0, gnt_w[1]}, 8'h04);
            check("t5_to", {7'b0, to_w[1]}, 8'h00);
        end

        // Active-low requests.
        do_reset();
        req = 4'b1111;
        #1;
        check("t6_idle1", {7'b0, idle_w[2]}, 8'h01);
        cycle();
        check("t6_nogrant", {4'b0, gnt_w[2]}, 8'h00);
        req = 4'b1110;
        #1;
        check("t6_idle0", {7'b0, idle_w[2]}, 8'h00);
        cycle();
        check("t6_gnt", {4'b0, gnt_w[2]}, 8'h01);

        // Sticky random requests with occasional resets.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 249) == 0) do_reset();
            else cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
